// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus widths, arbiter state encoding and slave address map
package bus_pkg;

    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 64;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } own_state_t;

    localparam logic [15:0] S0_BASE = 16'h0000;
    localparam logic [15:0] S0_LAST = 16'h07FF;
    localparam logic [15:0] S1_BASE = 16'h7000;
    localparam logic [15:0] S1_LAST = 16'h71FF;

endpackage

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master arbiter with hold-time fairness in front of the BUS master port
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int ADDR_W   = BUS_ADDR_W,
    parameter int DATA_W   = BUS_DATA_W,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_dout,
    output logic              m0_grant,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_dout,
    output logic              m1_grant,
    output logic [DATA_W-1:0] m_din,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_dout,
    input  logic [DATA_W-1:0] bus_din
);

    localparam int CNT_W = $clog2(MAX_HOLD) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    own_state_t       state;
    logic [CNT_W-1:0] hold_cnt;
    logic             own_req;
    logic             peer_req;

    always_comb begin
        own_req  = (state == OWN_M0) ? m0_req : m1_req;
        peer_req = (state == OWN_M0) ? m1_req : m0_req;
    end

    // The peer takes over either when the owner goes idle or when the owner
    // has used its full hold window while the peer was waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= OWN_M0;
            hold_cnt <= '0;
        end else if (peer_req && (!own_req || hold_cnt == HOLD_LAST)) begin
            state    <= (state == OWN_M0) ? OWN_M1 : OWN_M0;
            hold_cnt <= '0;
        end else if (own_req && peer_req) begin
            hold_cnt <= (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + 1'b1;
        end else begin
            hold_cnt <= '0;
        end
    end

    assign m0_grant = (state == OWN_M0);
    assign m1_grant = (state == OWN_M1);

    always_comb begin
        if (state == OWN_M0) begin
            bus_req  = m0_req;
            bus_wr   = m0_wr & m0_req;
            bus_addr = m0_addr;
            bus_dout = m0_dout;
        end else begin
            bus_req  = m1_req;
            bus_wr   = m1_wr & m1_req;
            bus_addr = m1_addr;
            bus_dout = m1_dout;
        end
    end

    assign m_din = bus_din;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed vector bench for bus_arbiter with MAX_HOLD=4
module tb_bus_arbiter;

    localparam int AW = 16;
    localparam int DW = 64;
    localparam int MH = 4;

    localparam logic [DW-1:0] D7 = 64'h7777777777777777;
    localparam logic [DW-1:0] D1 = 64'h1111111111111111;
    localparam logic [DW-1:0] DA = 64'hAAAAAAAAAAAAAAAA;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m0_wr, m1_req, m1_wr;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_dout, m1_dout;
    logic          m0_grant, m1_grant;
    logic [DW-1:0] m_din;
    logic          bus_req, bus_wr;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_dout;
    logic [DW-1:0] bus_din;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_dout(m0_dout), .m0_grant(m0_grant),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_dout(m1_dout), .m1_grant(m1_grant),
        .m_din(m_din), .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr),
        .bus_dout(bus_dout), .bus_din(bus_din)
    );

    typedef struct {
        logic          m0_req;
        logic          m0_wr;
        logic [AW-1:0] m0_addr;
        logic [DW-1:0] m0_dout;
        logic          m1_req;
        logic          m1_wr;
        logic [AW-1:0] m1_addr;
        logic [DW-1:0] m1_dout;
        logic [DW-1:0] din;
        logic          exp_m0g;
        logic          exp_req;
        logic          exp_wr;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_dout;
        logic [DW-1:0] exp_din;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Cycle-ordered vectors: outputs are checked against the state left
        // by the previous vectors, then the clock advances.
        vecs[0]  = '{0, 0, 16'h0100, 64'h0,  1, 1, 16'h7000, D7, DA, 1, 0, 0, 16'h0100, 64'h0,  DA};
        vecs[1]  = '{0, 0, 16'h0100, 64'h0,  1, 1, 16'h7000, D7, DA, 0, 1, 1, 16'h7000, D7,     DA};
        vecs[2]  = '{0, 0, 16'h0100, 64'h0,  0, 0, 16'h7000, D7, DA, 0, 0, 0, 16'h7000, D7,     DA};
        vecs[3]  = '{0, 0, 16'h0100, 64'h0,  0, 0, 16'h7000, D7, DA, 0, 0, 0, 16'h7000, D7,     DA};
        vecs[4]  = '{1, 0, 16'h0666, 64'h0,  0, 0, 16'h7000, D7, D1, 0, 0, 0, 16'h7000, D7,     D1};
        vecs[5]  = '{1, 0, 16'h0666, 64'h0,  0, 0, 16'h7000, D7, D1, 1, 1, 0, 16'h0666, 64'h0,  D1};
        vecs[6]  = '{0, 1, 16'h0666, 64'h55, 0, 0, 16'h7000, D7, D1, 1, 0, 0, 16'h0666, 64'h55, D1};
        vecs[7]  = '{1, 1, 16'h0666, 64'h55, 0, 0, 16'h7000, D7, D1, 1, 1, 1, 16'h0666, 64'h55, D1};
        vecs[8]  = '{0, 0, 16'h0200, 64'h0,  0, 0, 16'h7100, D7, DA, 1, 0, 0, 16'h0200, 64'h0,  DA};
        vecs[9]  = '{1, 0, 16'h0200, 64'h0,  1, 0, 16'h7100, D7, DA, 1, 1, 0, 16'h0200, 64'h0,  DA};
        vecs[10] = '{0, 0, 16'h0200, 64'h0,  1, 0, 16'h7100, D7, DA, 1, 0, 0, 16'h0200, 64'h0,  DA};
        vecs[11] = '{0, 0, 16'h0200, 64'h0,  1, 0, 16'h7100, D7, DA, 0, 1, 0, 16'h7100, D7,     DA};

        reset   = 1'b1;
        m0_req  = 1'b1; m0_wr = 1'b0; m0_addr = 16'h0100; m0_dout = '0;
        m1_req  = 1'b1; m1_wr = 1'b1; m1_addr = 16'h7004; m1_dout = D7;
        bus_din = '0;
        next_edge();
        next_edge();
        chk("reset_m0_grant", 64'(m0_grant), 64'd1);
        chk("reset_m1_grant", 64'(m1_grant), 64'd0);
        chk("reset_hold_cnt", 64'(dut.hold_cnt), 64'd0);
        chk("reset_bus_addr", 64'(bus_addr), 64'h0100);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            m0_req = vecs[i].m0_req; m0_wr = vecs[i].m0_wr;
            m0_addr = vecs[i].m0_addr; m0_dout = vecs[i].m0_dout;
            m1_req = vecs[i].m1_req; m1_wr = vecs[i].m1_wr;
            m1_addr = vecs[i].m1_addr; m1_dout = vecs[i].m1_dout;
            bus_din = vecs[i].din;
            #1;
            chk($sformatf("v%0d_m0_grant", i), 64'(m0_grant), 64'(vecs[i].exp_m0g));
            chk($sformatf("v%0d_m1_grant", i), 64'(m1_grant), 64'(!vecs[i].exp_m0g));
            chk($sformatf("v%0d_bus_req", i), 64'(bus_req), 64'(vecs[i].exp_req));
            chk($sformatf("v%0d_bus_wr", i), 64'(bus_wr), 64'(vecs[i].exp_wr));
            chk($sformatf("v%0d_bus_addr", i), 64'(bus_addr), 64'(vecs[i].exp_addr));
            chk($sformatf("v%0d_bus_dout", i), bus_dout, vecs[i].exp_dout);
            chk($sformatf("v%0d_m_din", i), m_din, vecs[i].exp_din);
            next_edge();
        end

        // Fairness: master 1 owns with a fresh counter; both now request forever.
        m0_req = 1'b1; m1_req = 1'b1;
        for (int i = 0; i < 24; i++) begin
            #1;
            chk($sformatf("fair%0d_m1_grant", i), 64'(m1_grant), 64'(((i / MH) % 2) == 0));
            chk($sformatf("fair%0d_exclusive", i), 64'(m0_grant ^ m1_grant), 64'd1);
            next_edge();
        end

        // Mid-transfer reset after two contended cycles of master 1 ownership.
        next_edge();
        next_edge();
        chk("pre_reset_m1_grant", 64'(m1_grant), 64'd1);
        reset = 1'b1;
        next_edge();
        reset = 1'b0;
        chk("midreset_m0_grant", 64'(m0_grant), 64'd1);
        chk("midreset_hold_cnt", 64'(dut.hold_cnt), 64'd0);
        for (int i = 0; i < MH + 1; i++) begin
            chk($sformatf("restart%0d_m0_grant", i), 64'(m0_grant), 64'(i < MH));
            next_edge();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter in front of the factorial system `BUS` master port. It shares the single master port between master 0 (host/testbench side) and master 1 (factorial core, which reads operands and writes results). Ownership is tracked in a registered 2-state FSM, with a hold-time limit for fairness. The arbiter's bus-side outputs connect directly to the `BUS` inputs `m_req`/`m_wr`/`m_addr`/`m_dout`, and `BUS` `m_din` returns through the arbiter.

## Interface
Parameters:
- `ADDR_W`, 16, address width (matches `BUS` `m_addr`)
- `DATA_W`, 64, data width (matches `BUS` `m_dout`/`m_din`)
- `MAX_HOLD`, 16, maximum consecutive owned cycles while the other master waits; legal range ≥ 2

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  reset; synchronous, active-high
- `m0_req`  in  1  master 0 bus request
- `m0_wr`  in  1  master 0 write enable
- `m0_addr`  in  ADDR_W  master 0 address
- `m0_dout`  in  DATA_W  master 0 write data
- `m0_grant`  out  1  master 0 owns the bus
- `m1_req`  in  1  master 1 bus request
- `m1_wr`  in  1  master 1 write enable
- `m1_addr`  in  ADDR_W  master 1 address
- `m1_dout`  in  DATA_W  master 1 write data
- `m1_grant`  out  1  master 1 owns the bus
- `m_din`  out  DATA_W  read data to both masters (valid for granted master only)
- `bus_req`  out  1  to `BUS` `m_req`
- `bus_wr`  out  1  to `BUS` `m_wr`
- `bus_addr`  out  ADDR_W  to `BUS` `m_addr`
- `bus_dout`  out  DATA_W  to `BUS` `m_dout`
- `bus_din`  in  DATA_W  from `BUS` `m_din`

## Operation
- FSM states: `OWN_M0` (reset state), `OWN_M1`. Grants are decoded from the state register:
  - `OWN_M0` → `m0_grant`=1, `m1_grant`=0
  - `OWN_M1` → `m0_grant`=0, `m1_grant`=1
  - Exactly one grant is high at all times.
- Hold counter `hold_cnt`:
  - Width $clog2(MAX_HOLD)+1; cleared on reset and on every ownership switch.
  - Increments each cycle the owner requests and the other master also requests.
  - Saturates at MAX_HOLD-1.
  - Otherwise cleared.
- Transition `OWN_M0`→`OWN_M1` when `m1_req` and either condition holds:
  - (a) `!m0_req`
  - (b) `hold_cnt == MAX_HOLD-1`
- `OWN_M1`→`OWN_M0` uses the mirror-image conditions.
- Otherwise the state is held. With both masters idle, the last owner keeps the grant (park).
- Bus-side mux (combinational from state):
  - Owner's `req`, `addr`, `dout` drive `bus_req`, `bus_addr`, `bus_dout`.
  - `bus_wr` = owner `wr` AND owner `req`, so no write occurs without a request.
  - Non-owner inputs are ignored entirely.
- `m_din` = `bus_din`, passed straight through to both masters.

## Timing
- Reset: at the next rising edge with `reset`=1, the FSM goes to `OWN_M0` and `hold_cnt`=0. Resulting outputs: `m0_grant`=1, `m1_grant`=0, and bus outputs follow master 0 inputs (all 0 if master 0 is idle).
- Reset mid-transfer aborts master 1 ownership at that edge; no state survives.
- Arbitration latency: a request to a free bus with the other master idle is granted at the first rising edge after `req` is sampled high, i.e. 1 cycle.
- Grant switch: the decision is taken at edge N and the new owner drives the bus from edge N onward. There is no dead cycle and no overlap.
- Simultaneous request from idle: the parked owner keeps the bus.
- Fairness:
  - A continuously requesting owner with a waiting peer loses the bus after exactly MAX_HOLD owned cycles.
  - The peer is then guaranteed the bus for up to MAX_HOLD cycles before the grant returns.
- Owner drops `req` in the same cycle the peer raises it: switch at the next edge.
- Owner write data and address pass combinationally to `BUS`, so `BUS` select and decode timing is unchanged.

## Structure
- Shared package `bus_pkg`:
  - `ADDR_W`/`DATA_W` defaults
  - state encoding `OWN_M0`=1'b0, `OWN_M1`=1'b1
  - slave address ranges: s0 0x0000–0x07FF, s1 0x7000–0x71FF
- No sub-module: FSM, counter and mux sit in one module.
- A system-level wrapper will instantiate `bus_arbiter` + `BUS`.

## Test plan
- Reset check: assert `reset` for 2 cycles with both masters requesting → `m0_grant`=1, `m1_grant`=0, `hold_cnt`=0, `bus_addr`=`m0_addr`.
- Handover: `m0_req`=0, `m1_req`=1, `m1_addr`=0x7000, `m1_wr`=1, `m1_dout`=0x7777777777777777. Required response:
  - `m1_grant`=1 after 1 edge
  - `bus_wr`=1, `bus_addr`=0x7000
  - `bus_dout` equals `m1_dout`
- Fairness: both masters request continuously with MAX_HOLD=4 → grants alternate every 4 cycles; `m0_grant` and `m1_grant` are never both high or both low.
- Park and read: after master 1 ownership both requests drop → `m1_grant` stays 1 and `bus_req`=0. Then set `m0_req`=1, `m0_addr`=0x0666 with s0 returning 0x1111111111111111 → `m0_grant`=1 next edge and `m_din`=0x1111111111111111.
- Write gating: the owner holds `wr`=1 with `req`=0 → `bus_wr`=0 and `bus_req`=0.
- Mid-transfer reset: while `OWN_M1` with a burst in progress, pulse `reset` 1 cycle → `m0_grant`=1 at that edge, and the counter restarts from 0 on the next contention.
